// File: rtl/shared_inv_mul_gf2.sv
// Share-wise GF(2^2) inversion of masked Q followed by two DOM-indep multipliers
// producing the masked halves of the GF(2^4) inverse: Ainv = E*B, Binv = E*A.

module shared_inv_mul_gf2_dom #(
  parameter int PIPELINED = 1,
  parameter int SHARES    = 2,
  parameter int NP        = SHARES*(SHARES-1)/2
) (
  input  logic                    ClkxCI,
  input  logic                    RstxRI,
  input  logic                    enable,
  input  logic [SHARES-1:0][1:0]  xSh,
  input  logic [SHARES-1:0][1:0]  ySh,
  input  logic [NP-1:0][1:0]      zPair,
  output logic [SHARES-1:0][1:0]  cSh
);

  // Normal basis {W^2, W}: bit 1 is the W^2 coefficient, bit 0 the W coefficient.
  function automatic logic [1:0] gfMul(input logic [1:0] a, input logic [1:0] b);
    logic t;
    t = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ t, (a[0] & b[0]) ^ t};
  endfunction

  function automatic int pairIdx(input int i, input int j);
    return i*SHARES - (i*(i+1))/2 + (j-i-1);
  endfunction

  logic [SHARES-1:0][1:0]             innerD, innerQ;
  logic [SHARES-1:0][SHARES-1:0][1:0] crossD, crossQ;

  always_comb begin
    innerD = '0;
    crossD = '0;
    for (int i = 0; i < SHARES; i++) begin
      innerD[i] = gfMul(xSh[i], ySh[i]);
      for (int j = 0; j < SHARES; j++) begin
        if (i < j)
          crossD[i][j] = gfMul(xSh[i], ySh[j]) ^ zPair[pairIdx(i, j)];
        else if (i > j)
          crossD[i][j] = gfMul(xSh[i], ySh[j]) ^ zPair[pairIdx(j, i)];
      end
    end
  end

  // Each cross term gets its own register so no two domains mix before a flop.
  always_ff @(posedge ClkxCI) begin
    if (RstxRI)      crossQ <= '0;
    else if (enable) crossQ <= crossD;
  end

  generate
    if (PIPELINED != 0) begin : gInnerReg
      always_ff @(posedge ClkxCI) begin
        if (RstxRI)      innerQ <= '0;
        else if (enable) innerQ <= innerD;
      end
    end else begin : gInnerComb
      assign innerQ = innerD;
    end
  endgenerate

  // Diagonal cross entries are constant zero, so folding them in is harmless.
  always_comb begin
    cSh = '0;
    for (int i = 0; i < SHARES; i++) begin
      cSh[i] = innerQ[i];
      for (int j = 0; j < SHARES; j++)
        cSh[i] = cSh[i] ^ crossQ[i][j];
    end
  end

endmodule

module shared_inv_mul_gf2 #(
  parameter int PIPELINED = 1,
  parameter int SHARES    = 2
) (
  input  logic                           ClkxCI,
  input  logic                           RstxRI,
  input  logic                           ValidxSI,
  input  logic [2*SHARES-1:0]            _QxDI,
  input  logic [2*SHARES-1:0]            _AxDI,
  input  logic [2*SHARES-1:0]            _BxDI,
  input  logic [2*SHARES*(SHARES-1)-1:0] _ZxDI,
  output logic [2*SHARES-1:0]            _AinvxDO,
  output logic [2*SHARES-1:0]            _BinvxDO,
  output logic                           ValidxSO
);

  localparam int ZW = SHARES*(SHARES-1);
  localparam int NP = ZW/2;

  logic [SHARES-1:0][1:0]       qSh, eSh;
  logic [1:0][SHARES-1:0][1:0]  ySel, cOut;
  logic [1:0][ZW-1:0]           zSel;
  logic                         vldQ;

  assign qSh = _QxDI;

  // Inversion in GF(2^2) is squaring, a plain bit swap and linear per share.
  always_comb begin
    eSh = '0;
    for (int i = 0; i < SHARES; i++)
      eSh[i] = {qSh[i][0], qSh[i][1]};
  end

  // Index 0 is multiplier A (E*B, low Z half), index 1 multiplier B (E*A).
  assign ySel = {_AxDI, _BxDI};
  assign zSel = _ZxDI;

  generate
    for (genvar m = 0; m < 2; m++) begin : gMul
      shared_inv_mul_gf2_dom #(
        .PIPELINED (PIPELINED),
        .SHARES    (SHARES),
        .NP        (NP)
      ) uMul (
        .ClkxCI (ClkxCI),
        .RstxRI (RstxRI),
        .enable (ValidxSI),
        .xSh    (eSh),
        .ySh    (ySel[m]),
        .zPair  (zSel[m]),
        .cSh    (cOut[m])
      );
    end
  endgenerate

  assign _AinvxDO = cOut[0];
  assign _BinvxDO = cOut[1];

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) vldQ <= 1'b0;
    else        vldQ <= ValidxSI;
  end

  assign ValidxSO = vldQ;

endmodule

// File: doc/shared_inv_mul_gf2.md
# shared_inv_mul_gf2

Downstream stage of `shared_XmulBxorsqsc_gf2` inside the DOM-masked GF(2^4) inverter of the AES S-box. It takes the masked GF(2^2) value Q = A·B ⊕ sqsc(A ⊕ B) and inverts it share-wise. It then multiplies the inverse E with both nibble halves using two domain-oriented-masking (DOM-indep) GF(2^2) multipliers, producing the masked high and low halves of the GF(2^4) inverse. It carries a valid flag so the S-box pipeline controller can track data through its register stage.

## Interface
- PIPELINED, 1, 1: inner-domain terms are registered (all outputs driven from flops); 0: inner terms are combinational from the inputs.
- SHARES, 2, number of masking shares (d+1); legal values are ≥ 2.

- ClkxCI  in  1  clock; rising-edge active.
- RstxRI  in  1  reset; synchronous, active-high.
- ValidxSI  in  1  input shares are valid this cycle; acts as the register enable.
- _QxDI  in  2*SHARES  masked Q; share i occupies bits [2i+1:2i].
- _AxDI  in  2*SHARES  masked high half A of the GF(2^4) operand, packed the same way.
- _BxDI  in  2*SHARES  masked low half B, packed the same way.
- _ZxDI  in  2*SHARES*(SHARES-1)  fresh randomness. Lower SHARES*(SHARES-1) bits feed multiplier A; upper bits feed multiplier B. Each pair i<j takes 2 bits, in pair-enumeration order.
- _AinvxDO  out  2*SHARES  masked E·B (new high half).
- _BinvxDO  out  2*SHARES  masked E·A (new low half).
- ValidxSO  out  1  outputs valid.

## Operation
- GF(2^2) uses the normal basis {W², W}. Multiplication of a=(a1,a0) and b=(b1,b0):
  - t = (a1⊕a0)&(b1⊕b0)
  - c1 = (a1&b1)⊕t
  - c0 = (a0&b0)⊕t
- Inversion equals squaring, which is a bit swap: E_i = {Q_i[0], Q_i[1]}. It is applied per share; no randomness and no register.
- Each multiplier (X = E, Y = B or A) works as follows:
  - Inner term for share i: X_i·Y_i.
  - Cross term for i≠j: X_i·Y_j ⊕ Z_{min(i,j),max(i,j)}. The same Z is used for (i,j) and (j,i).
  - Every cross term is registered separately. Terms are never combined before the register.
  - Output share i = XOR of its inner term and all its registered cross terms of share i.
- Register enable is ValidxSI. When ValidxSI=0, all term registers hold their value.
- With PIPELINED=0, upstream holds _QxDI/_AxDI/_BxDI stable through the cycle after ValidxSI.
- ValidxSO is a one-cycle delayed copy of ValidxSI.
- Unmasked correctness: XOR over shares of _AinvxDO = Q⁻¹·B and of _BinvxDO = Q⁻¹·A (with 0⁻¹ = 0), for any Z.

## Timing
- Latency is 1 cycle. Inputs sampled at edge k appear on the outputs after edge k, together with ValidxSO=1.
- Throughput is one operand set per cycle. There is no backpressure.
- Reset (RstxRI=1 at an edge) clears all term registers and ValidxSO to 0.
  - Reset values: _AinvxDO=0 and _BinvxDO=0 when PIPELINED=1. With PIPELINED=0, the outputs equal the combinational inner terms.
  - Reset wins over ValidxSI=1 at the same edge.
  - Reset mid-stream drops the in-flight item; the first valid after reset release has normal latency.
- Back-to-back valids: each edge overwrites the registers. ValidxSO stays high continuously.
- Bubble (ValidxSI=0): ValidxSO=0 next cycle and the output shares hold their last value.
- Z is consumed only at edges where ValidxSI=1.

## Test plan
- Reset: hold RstxRI=1 with random inputs and ValidxSI=1 → ValidxSO=0 and all output shares 0 (PIPELINED=1).
- Known values: unmasked Q=01, A=11, B=01, random masks and Z → one cycle later the recombined Ainv=11, Binv=10, ValidxSO=1.
- Identity: Q=11 (unity), A=10, B=01 → Ainv=01, Binv=10. Also Q=00 with any A, B → both outputs 00.
- Exhaustive: SHARES=2, all 4^6 share combinations of Q/A/B with random Z every cycle, streamed back-to-back → recombined outputs match the reference model at 1-cycle latency for every vector.
- Bubble/reset: valid, bubble, valid, then a reset asserted with a valid in flight → ValidxSO pattern 1,0,1,0, outputs held during the bubble, and the registers zeroed after the reset.
- Parameters: repeat the exhaustive run with PIPELINED=0, and with SHARES=3 (random sampling) → functional results identical.
